// File: rtl/msg_ring_reader_if.sv
// Byte-stream and ring-RAM read signals shared between msg_ring_reader and its neighbours.
// master = the reader; slave = the RAM/consumer side.
interface msg_ring_reader_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic [AW-1:0] raddr_o;
  logic [DW-1:0] rdata_i;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i;
  logic          first_o;
  logic          last_o;

  modport master (
    output raddr_o,
    input  rdata_i,
    output byte_o,
    output byte_valid_o,
    input  byte_ready_i,
    output first_o,
    output last_o
  );

  modport slave (
    input  raddr_o,
    output rdata_i,
    input  byte_o,
    input  byte_valid_o,
    output byte_ready_i,
    input  first_o,
    input  last_o
  );
endinterface

// File: rtl/msg_ring_reader.sv
// Drains length-prefixed messages from a registered-read RAM ring and emits them as a
// little-endian byte stream with valid/ready, first/last markers and bad-header flush.
module msg_ring_reader #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          enable_i,
  input  logic [AW-1:0] wp_i,
  output logic [AW-1:0] rp_o,
  output logic          busy_o,
  output logic          err_o,
  msg_ring_reader_if.master rbus
);

  localparam int BPW = DW / 8;
  localparam int LB  = $clog2(BPW);
  localparam int CW  = ((LW + 1 > AW) ? LW + 1 : AW) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_PAYLOAD,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [DW-1:0] r_word;

  logic [AW-1:0] w_occ;
  logic [LW-1:0] w_hdrLen;
  logic [LW:0]   w_lenRound;
  logic [LW:0]   w_hdrNw;
  logic [CW-1:0] w_need;
  logic          w_hdrBad;
  logic [LB-1:0] w_lane;
  logic          w_valid;
  logic          w_accept;
  logic          w_lastByte;
  logic          w_lastLane;

  assign w_occ      = wp_i - r_rp;
  assign w_hdrLen   = rbus.rdata_i[LW-1:0];
  assign w_lenRound = {1'b0, w_hdrLen} + (LW + 1)'(BPW - 1);
  assign w_hdrNw    = w_lenRound >> LB;
  // Header plus payload must already be in the ring, otherwise the header is treated as corrupt.
  assign w_need     = CW'(w_hdrNw) + CW'(1);
  assign w_hdrBad   = (w_hdrLen == '0) || (w_need > CW'(w_occ));

  assign w_lane     = r_idx[LB-1:0];
  assign w_valid    = (r_state == S_PAYLOAD);
  assign w_accept   = w_valid && rbus.byte_ready_i;
  assign w_lastByte = (r_idx == (r_len - LW'(1)));
  assign w_lastLane = &w_lane;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable_i && (w_occ != '0)) w_next = S_HDR;
      S_HDR:     w_next = w_hdrBad ? S_ERR : S_LOAD;
      S_LOAD:    w_next = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_accept) begin
          if (w_lastByte) begin
            w_next = S_COMMIT;
          end else if (w_lastLane) begin
            w_next = S_LOAD;
          end
        end
      end
      S_COMMIT:  w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // r_addr starts at rp+1 and steps once per LOAD, so after the last word it is the next header address.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rp   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_word <= '0;
    end else begin
      case (r_state)
        S_IDLE:    r_addr <= r_rp + AW'(1);
        S_HDR: begin
          r_len <= w_hdrLen;
          r_idx <= '0;
        end
        S_LOAD: begin
          r_word <= rbus.rdata_i;
          r_addr <= r_addr + AW'(1);
        end
        S_PAYLOAD: if (w_accept) r_idx <= r_idx + LW'(1);
        S_COMMIT:  r_rp <= r_addr;
        S_ERR:     r_rp <= wp_i;
        default:   ;
      endcase
    end
  end

  assign rbus.raddr_o      = (r_state == S_IDLE) ? r_rp : r_addr;
  assign rbus.byte_valid_o = w_valid;
  assign rbus.byte_o       = w_valid ? 8'(r_word >> {w_lane, 3'b000}) : 8'h00;
  assign rbus.first_o      = w_valid && (r_idx == '0);
  assign rbus.last_o       = w_valid && w_lastByte;
  assign rp_o              = r_rp;
  assign busy_o            = (r_state != S_IDLE);
  assign err_o             = (r_state == S_ERR);

endmodule

// File: tb/tb_msg_ring_reader.sv
// Directed bench for msg_ring_reader: a DW=32 and a DW=64 instance, each with a registered-read RAM model.
module tb_msg_ring_reader;
  localparam int AW = 8;
  localparam int LW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn = 1'b1;
  logic          en32, en64;
  logic [AW-1:0] wp32, wp64, rp32, rp64;
  logic          busy32, busy64, err32, err64;

  msg_ring_reader_if #(.DW(32), .AW(AW)) if32 ();
  msg_ring_reader_if #(.DW(64), .AW(AW)) if64 ();

  logic [31:0] ram32 [0:255];
  logic [63:0] ram64 [0:255];

  always @(posedge clk) begin
    if32.rdata_i <= ram32[if32.raddr_o];
    if64.rdata_i <= ram64[if64.raddr_o];
  end

  msg_ring_reader #(.DW(32), .AW(AW), .LW(LW)) dut32 (
    .clk(clk), .aresetn(aresetn), .enable_i(en32), .wp_i(wp32), .rp_o(rp32),
    .busy_o(busy32), .err_o(err32), .rbus(if32)
  );

  msg_ring_reader #(.DW(64), .AW(AW), .LW(LW)) dut64 (
    .clk(clk), .aresetn(aresetn), .enable_i(en64), .wp_i(wp64), .rp_o(rp64),
    .busy_o(busy64), .err_o(err64), .rbus(if64)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] gotByte[$];
  bit         gotFirst[$];
  bit         gotLast[$];
  int         gotCycle[$];
  int         errSeen, stallSeen, unstable, doneCycle;
  bit         timedOut;

  task automatic doReset();
    aresetn = 1'b0;
    en32 = 1'b0;
    en64 = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge: raises enable, then records every accepted byte until the FSM returns to IDLE.
  task automatic drain(input bit sel64, input bit useRand, input int maxCycles);
    logic [15:0] patt;
    bit sawBusy, hv, rdy;
    logic [7:0] hb, d;
    logic hf, hl, v, f, l, b, e;
    patt = 16'b1110_1001_1100_1001;
    gotByte.delete(); gotFirst.delete(); gotLast.delete(); gotCycle.delete();
    errSeen = 0; stallSeen = 0; unstable = 0; doneCycle = -1; timedOut = 1'b1;
    sawBusy = 1'b0; hv = 1'b0; hb = '0; hf = 1'b0; hl = 1'b0;
    if (sel64) en64 = 1'b1; else en32 = 1'b1;
    for (int c = 1; c <= maxCycles; c++) begin
      @(negedge clk);
      v = sel64 ? if64.byte_valid_o : if32.byte_valid_o;
      d = sel64 ? if64.byte_o       : if32.byte_o;
      f = sel64 ? if64.first_o      : if32.first_o;
      l = sel64 ? if64.last_o       : if32.last_o;
      b = sel64 ? busy64            : busy32;
      e = sel64 ? err64             : err32;
      if (e) errSeen++;
      if (hv && (v !== 1'b1 || d !== hb || f !== hf || l !== hl)) unstable++;
      if (b) begin
        sawBusy = 1'b1;
        if (sel64) en64 = 1'b0; else en32 = 1'b0;
      end else if (sawBusy) begin
        doneCycle = c;
        timedOut = 1'b0;
        break;
      end
      rdy = useRand ? patt[c % 16] : 1'b1;
      if (sel64) if64.byte_ready_i = rdy; else if32.byte_ready_i = rdy;
      if (v && rdy) begin
        gotByte.push_back(d); gotFirst.push_back(f); gotLast.push_back(l); gotCycle.push_back(c);
        hv = 1'b0;
      end else if (v) begin
        hv = 1'b1; hb = d; hf = f; hl = l;
        stallSeen++;
      end else begin
        hv = 1'b0;
      end
    end
    if32.byte_ready_i = 1'b1;
    if64.byte_ready_i = 1'b1;
  endtask

  task automatic loadBasic();
    ram32[0] = 32'hABCD_0005;
    ram32[1] = 32'h4443_4241;
    ram32[2] = 32'h0000_0045;
    wp32 = 8'd3;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    total++; if (rp32 !== 8'd0 || if32.raddr_o !== 8'd0) begin bad++; $display("FAIL reset_ptr32 rp=%0d raddr=%0d want 0/0", rp32, if32.raddr_o); end
    total++; if ({busy32, err32, if32.byte_valid_o, if32.first_o, if32.last_o} !== 5'b0) begin bad++; $display("FAIL reset_flags32 got=%b want=00000", {busy32, err32, if32.byte_valid_o, if32.first_o, if32.last_o}); end
    total++; if (if32.byte_o !== 8'h00) begin bad++; $display("FAIL reset_byte32 got=%h want=00", if32.byte_o); end
    total++; if (rp64 !== 8'd0 || busy64 !== 1'b0 || if64.byte_valid_o !== 1'b0) begin bad++; $display("FAIL reset_dut64 rp=%0d busy=%b valid=%b want 0", rp64, busy64, if64.byte_valid_o); end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] expB [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    int expC [5] = '{3, 4, 5, 6, 8};
    doReset();
    loadBasic();
    drain(1'b0, 1'b0, 40);
    total++; if (timedOut !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", timedOut); end
    total++; if (gotByte.size() != 5) begin bad++; $display("FAIL basic_count got=%0d want=5", gotByte.size()); end
    for (int i = 0; i < 5 && i < gotByte.size(); i++) begin
      total++; if (gotByte[i] !== expB[i]) begin bad++; $display("FAIL basic_byte[%0d] got=%h want=%h", i, gotByte[i], expB[i]); end
      total++; if (gotCycle[i] != expC[i]) begin bad++; $display("FAIL basic_cycle[%0d] got=%0d want=%0d", i, gotCycle[i], expC[i]); end
      total++; if (gotFirst[i] !== (i == 0) || gotLast[i] !== (i == 4)) begin bad++; $display("FAIL basic_marks[%0d] got first=%b last=%b", i, gotFirst[i], gotLast[i]); end
    end
    total++; if (errSeen != 0) begin bad++; $display("FAIL basic_err got=%0d want=0", errSeen); end
    total++; if (rp32 !== 8'd3) begin bad++; $display("FAIL basic_rp got=%0d want=3", rp32); end
    total++; if (doneCycle != 10) begin bad++; $display("FAIL basic_idle_cycle got=%0d want=10", doneCycle); end
  endtask

  task automatic test_backpressure();
    logic [7:0] expB [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    int expC [5] = '{3, 6, 7, 8, 11};
    doReset();
    loadBasic();
    drain(1'b0, 1'b1, 60);
    total++; if (gotByte.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", gotByte.size()); end
    for (int i = 0; i < 5 && i < gotByte.size(); i++) begin
      total++; if (gotByte[i] !== expB[i] || gotCycle[i] != expC[i]) begin bad++; $display("FAIL bp_byte[%0d] got=%h@%0d want=%h@%0d", i, gotByte[i], gotCycle[i], expB[i], expC[i]); end
      total++; if (gotFirst[i] !== (i == 0) || gotLast[i] !== (i == 4)) begin bad++; $display("FAIL bp_marks[%0d] got first=%b last=%b", i, gotFirst[i], gotLast[i]); end
    end
    total++; if (stallSeen != 3) begin bad++; $display("FAIL bp_stalls got=%0d want=3", stallSeen); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", unstable); end
    total++; if (doneCycle != 13 || rp32 !== 8'd3) begin bad++; $display("FAIL bp_commit got idle@%0d rp=%0d want idle@13 rp=3", doneCycle, rp32); end
  endtask

  task automatic test_bad_headers();
    doReset();
    ram32[0] = 32'h0000_FC00;
    wp32 = 8'd1;
    drain(1'b0, 1'b0, 20);
    total++; if (errSeen != 1) begin bad++; $display("FAIL badlen0_err got=%0d pulses want=1", errSeen); end
    total++; if (gotByte.size() != 0) begin bad++; $display("FAIL badlen0_bytes got=%0d want=0", gotByte.size()); end
    total++; if (rp32 !== 8'd1 || doneCycle != 3) begin bad++; $display("FAIL badlen0_rp got rp=%0d idle@%0d want rp=1 idle@3", rp32, doneCycle); end
    ram32[1] = 32'd12;
    wp32 = 8'd3;
    drain(1'b0, 1'b0, 20);
    total++; if (errSeen != 1 || gotByte.size() != 0) begin bad++; $display("FAIL badocc_err got err=%0d bytes=%0d want 1/0", errSeen, gotByte.size()); end
    total++; if (rp32 !== 8'd3) begin bad++; $display("FAIL badocc_rp got=%0d want=3", rp32); end
  endtask

  task automatic test_wrap();
    ram32[3] = 32'd0;
    wp32 = 8'd254;
    drain(1'b0, 1'b0, 20);
    total++; if (rp32 !== 8'd254 || errSeen != 1) begin bad++; $display("FAIL wrap_setup got rp=%0d err=%0d want 254/1", rp32, errSeen); end
    ram32[254] = 32'd8;
    ram32[255] = 32'h1312_1110;
    ram32[0]   = 32'h1716_1514;
    wp32 = 8'd1;
    drain(1'b0, 1'b0, 40);
    total++; if (gotByte.size() != 8) begin bad++; $display("FAIL wrap_count got=%0d want=8", gotByte.size()); end
    for (int i = 0; i < 8 && i < gotByte.size(); i++) begin
      total++; if (gotByte[i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap_byte[%0d] got=%h want=%h", i, gotByte[i], 8'(8'h10 + i)); end
    end
    total++; if (gotLast.size() == 8 && (gotLast[7] !== 1'b1 || gotFirst[0] !== 1'b1)) begin bad++; $display("FAIL wrap_marks got first0=%b last7=%b want 1/1", gotFirst[0], gotLast[7]); end
    total++; if (rp32 !== 8'd1 || errSeen != 0 || doneCycle != 13) begin bad++; $display("FAIL wrap_rp got rp=%0d err=%0d idle@%0d want 1/0/13", rp32, errSeen, doneCycle); end
  endtask

  task automatic test_dw64();
    @(negedge clk);
    ram64[0] = 64'd9;
    ram64[1] = 64'h0807_0605_0403_0201;
    ram64[2] = 64'hDEAD_BEEF_CAFE_F009;
    wp64 = 8'd3;
    drain(1'b1, 1'b0, 40);
    total++; if (gotByte.size() != 9) begin bad++; $display("FAIL dw64_count got=%0d want=9", gotByte.size()); end
    for (int i = 0; i < 9 && i < gotByte.size(); i++) begin
      total++; if (gotByte[i] !== 8'(i + 1) || gotCycle[i] != ((i < 8) ? i + 3 : 12)) begin bad++; $display("FAIL dw64_byte[%0d] got=%h@%0d want=%h@%0d", i, gotByte[i], gotCycle[i], 8'(i + 1), (i < 8) ? i + 3 : 12); end
    end
    total++; if (gotLast.size() == 9 && (gotLast[8] !== 1'b1 || gotLast[7] !== 1'b0)) begin bad++; $display("FAIL dw64_last got last7=%b last8=%b want 0/1", gotLast[7], gotLast[8]); end
    total++; if (rp64 !== 8'd3 || doneCycle != 14) begin bad++; $display("FAIL dw64_rp got rp=%0d idle@%0d want 3/14", rp64, doneCycle); end
  endtask

  task automatic test_reset_enable();
    int busyCount;
    doReset();
    loadBasic();
    en32 = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (if32.byte_valid_o !== 1'b1 || if32.byte_o !== 8'h42) begin bad++; $display("FAIL rstmid_pre got valid=%b byte=%h want 1/42", if32.byte_valid_o, if32.byte_o); end
    aresetn = 1'b0;
    en32 = 1'b0;
    #1;
    total++; if ({busy32, err32, if32.byte_valid_o, if32.first_o, if32.last_o} !== 5'b0) begin bad++; $display("FAIL rstmid_flags got=%b want=00000", {busy32, err32, if32.byte_valid_o, if32.first_o, if32.last_o}); end
    total++; if (rp32 !== 8'd0 || if32.raddr_o !== 8'd0 || if32.byte_o !== 8'h00) begin bad++; $display("FAIL rstmid_data got rp=%0d raddr=%0d byte=%h want 0", rp32, if32.raddr_o, if32.byte_o); end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    busyCount = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy32) busyCount++;
    end
    total++; if (busyCount != 0) begin bad++; $display("FAIL en_hold got busy=%0d cycles want=0", busyCount); end
    drain(1'b0, 1'b0, 40);
    total++; if (gotCycle.size() != 5 || gotCycle[0] != 3) begin bad++; $display("FAIL en_start got count=%0d want 5 bytes from cycle 3", gotCycle.size()); end
    total++; if (rp32 !== 8'd3) begin bad++; $display("FAIL en_rp got=%0d want=3", rp32); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram32[i] = '0;
      ram64[i] = '0;
    end
    en32 = 1'b0; en64 = 1'b0;
    wp32 = '0; wp64 = '0;
    if32.byte_ready_i = 1'b1;
    if64.byte_ready_i = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_headers();
    test_wrap();
    test_dw64();
    test_reset_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
